mips_multicycle_control: RTL and testbench

//  Multi-cycle MIPS control FSM. It is the producer of every select that data_path consumes
//  (write_addr3_sel, reg_write_data_sel, alu_src_b_sel, PC_sel), plus register, memory and
//  mul/div strobes. It sequences fetch/decode/execute/mem/writeback with ready handshakes to

---
 rtl/mips_multicycle_control.sv | 167 ++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multi-cycle MIPS control FSM driving datapath selects, memory strobes
// and the mul/div handshake.
module mips_multicycle_control #(
    parameter int MD_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        alu_zero,
    input  logic        md_done,
    output logic        imem_req,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  PC_sel,
    output logic        write_addr3_sel,
    output logic [1:0]  reg_write_data_sel,
    output logic        alu_src_b_sel,
    output logic [2:0]  alu_control,
    output logic        reg_write_en,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        md_start,
    output logic        md_op,
    output logic        illegal_instr,
    output logic        md_timeout
);
    localparam int CW = $clog2(MD_TIMEOUT);
    localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B,
                           OP_BEQ = 6'h04, OP_J = 6'h02;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25,
                           F_SLT = 6'h2A, F_MULT = 6'h18, F_DIV = 6'h1A, F_MFHI = 6'h10,
                           F_MFLO = 6'h12;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, MD_WAIT} state_t;
    state_t state, state_next;
    logic [5:0] op, funct;
    logic [CW-1:0] md_cnt;
    logic is_r, is_alu, is_md, is_mf, is_addi, is_lw, is_sw, is_beq, is_j, legal, md_expired;
    logic [2:0] r_alu_ctl;
    logic unused_bits;

    assign unused_bits = ^instruction[25:6];
    assign is_r    = op == OP_R;
    assign is_alu  = is_r && (funct == F_ADD || funct == F_SUB || funct == F_AND ||
                              funct == F_OR || funct == F_SLT);
    assign is_md   = is_r && (funct == F_MULT || funct == F_DIV);
    assign is_mf   = is_r && (funct == F_MFHI || funct == F_MFLO);
    assign is_addi = op == OP_ADDI;
    assign is_lw   = op == OP_LW;
    assign is_sw   = op == OP_SW;
    assign is_beq  = op == OP_BEQ;
    assign is_j    = op == OP_J;
    assign legal   = is_alu || is_md || is_mf || is_addi || is_lw || is_sw || is_beq || is_j;
    assign md_expired = md_cnt == CW'(MD_TIMEOUT - 1);
    assign r_alu_ctl = funct == F_SUB ? 3'b110 :
                       funct == F_AND ? 3'b000 :
                       funct == F_OR  ? 3'b001 :
                       funct == F_SLT ? 3'b111 : 3'b010;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op     <= '0;
            funct  <= '0;
            md_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == FETCH && imem_ready) begin
                op    <= instruction[31:26];
                funct <= instruction[5:0];
            end
            if (state == EXEC)
                md_cnt <= '0;
            else if (state == MD_WAIT)
                md_cnt <= md_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next         = state;
        imem_req           = 1'b0;
        ir_write           = 1'b0;
        pc_write           = 1'b0;
        PC_sel             = 2'd0;
        write_addr3_sel    = 1'b0;
        reg_write_data_sel = 2'd0;
        alu_src_b_sel      = 1'b0;
        alu_control        = 3'b000;
        reg_write_en       = 1'b0;
        dmem_req           = 1'b0;
        dmem_we            = 1'b0;
        md_start           = 1'b0;
        md_op              = 1'b0;
        illegal_instr      = 1'b0;
        md_timeout         = 1'b0;
        case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (is_j) begin
                    pc_write   = 1'b1;
                    PC_sel     = 2'd2;
                    state_next = FETCH;
                end else if (!legal) begin
                    illegal_instr = 1'b1;
                    state_next    = FETCH;
                end else
                    state_next = EXEC;
            end
            EXEC: begin
                if (is_alu) begin
                    alu_control = r_alu_ctl;
                    state_next  = WB;
                end else if (is_addi || is_lw || is_sw) begin
                    alu_src_b_sel = 1'b1;
                    alu_control   = 3'b010;
                    state_next    = is_addi ? WB : MEM;
                end else if (is_beq) begin
                    alu_control = 3'b110;
                    pc_write    = alu_zero;
                    PC_sel      = {1'b0, alu_zero};
                    state_next  = FETCH;
                end else if (is_md) begin
                    md_start   = 1'b1;
                    md_op      = funct == F_DIV;
                    state_next = MD_WAIT;
                end else begin
                    reg_write_en       = 1'b1;
                    reg_write_data_sel = funct == F_MFHI ? 2'd2 : 2'd3;
                    state_next         = FETCH;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_sw;
                if (dmem_ready)
                    state_next = is_sw ? FETCH : WB;
            end
            WB: begin
                reg_write_en       = 1'b1;
                write_addr3_sel    = !is_r;
                reg_write_data_sel = is_lw ? 2'd1 : 2'd0;
                state_next         = FETCH;
            end
            MD_WAIT: begin
                md_op = funct == F_DIV;
                // done takes priority over an expiring counter in the same cycle
                if (md_done)
                    state_next = FETCH;
                else if (md_expired) begin
                    md_timeout = 1'b1;
                    state_next = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: random and directed instruction scripts checked cycle by cycle
// against a per-instruction-class reference of expected control outputs.
module tb_mips_multicycle_control;
    localparam int T = 8;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] instruction = '0;
    logic        imem_ready = 1'b0, dmem_ready = 1'b0, alu_zero = 1'b0, md_done = 1'b0;
    logic        imem_req, ir_write, pc_write, write_addr3_sel, alu_src_b_sel, reg_write_en;
    logic        dmem_req, dmem_we, md_start, md_op, illegal_instr, md_timeout;
    logic [1:0]  PC_sel, reg_write_data_sel;
    logic [2:0]  alu_control;

    mips_multicycle_control #(.MD_TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .alu_zero(alu_zero), .md_done(md_done),
        .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .PC_sel(PC_sel),
        .write_addr3_sel(write_addr3_sel), .reg_write_data_sel(reg_write_data_sel),
        .alu_src_b_sel(alu_src_b_sel), .alu_control(alu_control), .reg_write_en(reg_write_en),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .md_start(md_start), .md_op(md_op),
        .illegal_instr(illegal_instr), .md_timeout(md_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic imem_req, ir_write, pc_write;
        logic [1:0] pc_sel;
        logic wa3;
        logic [1:0] wds;
        logic srcb;
        logic [2:0] aluc;
        logic rwe, dreq, dwe, mds, mdop, ill, mto;
    } o_t;
    typedef enum {C_ALU, C_ADDI, C_LW, C_SW, C_BEQ, C_J, C_MULT, C_DIV, C_MFHI, C_MFLO, C_ILL} cls_t;

    o_t got;
    assign got = {imem_req, ir_write, pc_write, PC_sel, write_addr3_sel, reg_write_data_sel,
                  alu_src_b_sel, alu_control, reg_write_en, dmem_req, dmem_we, md_start, md_op,
                  illegal_instr, md_timeout};

    int n_cmp = 0, n_err = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // 0/1 drive that value; 2 drives a random stray value the DUT must ignore
    task automatic cyc(string tag, int ir, int dr, int md, int z, logic [31:0] ins, o_t e);
        @(negedge clk);
        imem_ready  = ir == 2 ? 1'($urandom) : ir[0];
        dmem_ready  = dr == 2 ? 1'($urandom) : dr[0];
        md_done     = md == 2 ? 1'($urandom) : md[0];
        alu_zero    = z == 2 ? 1'($urandom) : z[0];
        instruction = ins;
        #1 check(tag, {13'b0, got}, {13'b0, e});
    endtask

    function automatic cls_t classify(logic [31:0] w);
        case (w[31:26])
            6'h00: case (w[5:0])
                6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: return C_ALU;
                6'h18: return C_MULT;
                6'h1A: return C_DIV;
                6'h10: return C_MFHI;
                6'h12: return C_MFLO;
                default: return C_ILL;
            endcase
            6'h08: return C_ADDI;
            6'h23: return C_LW;
            6'h2B: return C_SW;
            6'h04: return C_BEQ;
            6'h02: return C_J;
            default: return C_ILL;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(logic [5:0] f);
        case (f)
            6'h22: return 3'b110;
            6'h24: return 3'b000;
            6'h25: return 3'b001;
            6'h2A: return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic logic [31:0] gen();
        logic [5:0] fl [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18, 6'h1A, 6'h10, 6'h12};
        logic [5:0] ol [5] = '{6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};
        int k = $urandom_range(0, 15);
        logic [31:0] w = $urandom;
        if (k < 9) begin
            w[31:26] = 6'h00;
            w[5:0] = fl[k];
        end else if (k < 14)
            w[31:26] = ol[k-9];
        else
            for (int i = 0; i < 50 && classify(w) != C_ILL; i++) begin
                w = $urandom;
                if (k == 15) w[31:26] = 6'h00;
            end
        return w;
    endfunction

    // Expected output trace of one instruction, entered in FETCH and ending on return to FETCH
    task automatic run(logic [31:0] ins, int idly, int ddly, int mdly, bit z);
        cls_t c = classify(ins);
        o_t e;
        for (int i = 0; i < idly; i++) begin
            e = '0; e.imem_req = 1;
            cyc("fetch_wait", 0, 2, 2, 2, $urandom, e);
        end
        e = '0; e.imem_req = 1; e.ir_write = 1; e.pc_write = 1;
        cyc("fetch", 1, 2, 2, 2, ins, e);
        e = '0;
        if (c == C_J) begin e.pc_write = 1; e.pc_sel = 2; end
        if (c == C_ILL) e.ill = 1;
        cyc("decode", 2, 2, 2, 2, $urandom, e);
        if (c == C_J || c == C_ILL) return;
        e = '0;
        case (c)
            C_ALU: e.aluc = alu_of(ins[5:0]);
            C_ADDI, C_LW, C_SW: begin e.srcb = 1; e.aluc = 3'b010; end
            C_BEQ: begin e.aluc = 3'b110; e.pc_write = z; e.pc_sel = {1'b0, z}; end
            C_MULT, C_DIV: begin e.mds = 1; e.mdop = c == C_DIV; end
            default: begin e.rwe = 1; e.wds = c == C_MFHI ? 2'd2 : 2'd3; end
        endcase
        cyc("exec", 2, 2, 2, c == C_BEQ ? int'(z) : 2, $urandom, e);
        if (c == C_LW || c == C_SW) begin
            e = '0; e.dreq = 1; e.dwe = c == C_SW;
            for (int i = 0; i < ddly; i++) cyc("mem_wait", 2, 0, 2, 2, $urandom, e);
            cyc("mem", 2, 1, 2, 2, $urandom, e);
        end
        if (c == C_MULT || c == C_DIV)
            for (int k = 0; k < T; k++) begin
                bit d = k == mdly;
                e = '0; e.mdop = c == C_DIV; e.mto = !d && k == T - 1;
                cyc("md_wait", 2, 2, int'(d), 2, $urandom, e);
                if (d) break;
            end
        if (c == C_ALU || c == C_ADDI || c == C_LW) begin
            e = '0; e.rwe = 1; e.wa3 = c != C_ALU; e.wds = c == C_LW ? 2'd1 : 2'd0;
            cyc("wb", 2, 2, 2, 2, $urandom, e);
        end
    endtask

    initial begin
        o_t e;
        repeat (2) cyc("in_reset", 2, 2, 2, 2, $urandom, '0);
        @(negedge clk);
        rst_n = 1'b1;
        imem_ready = 1'b1;
        #1 check("idle", {13'b0, got}, 32'd0);
        run(32'h012A4020, 5, 0, 0, 0);
        run(32'h8C880004, 0, 3, 0, 0);
        run(32'h1109FFFC, 0, 0, 0, 1);
        run(32'h1109FFFC, 0, 0, 0, 0);
        run(32'h01090018, 0, 0, 5, 0);
        run(32'h01090018, 1, 0, 100, 0);
        run(32'h0109001A, 0, 0, T - 1, 0);
        run(32'h0109001A, 0, 0, 0, 0);
        run(32'hFC000000, 0, 0, 0, 0);
        run(32'h2108FFFF, 0, 0, 0, 0);
        run(32'hAD090008, 2, 1, 0, 0);
        run(32'h08000010, 0, 0, 0, 0);
        run(32'h00004010, 0, 0, 0, 0);
        run(32'h00004012, 0, 0, 0, 0);
        run(32'h012A402A, 0, 0, 0, 0);
        // reset asserted while an LW waits in MEM
        e = '0; e.imem_req = 1; e.ir_write = 1; e.pc_write = 1;
        cyc("fetch_r", 1, 2, 2, 2, 32'h8C880004, e);
        cyc("decode_r", 2, 2, 2, 2, $urandom, '0);
        e = '0; e.srcb = 1; e.aluc = 3'b010;
        cyc("exec_r", 2, 2, 2, 2, $urandom, e);
        e = '0; e.dreq = 1;
        cyc("mem_r", 2, 0, 2, 2, $urandom, e);
        #2 rst_n = 1'b0;
        #1 check("async_rst", {13'b0, got}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("idle_after_rst", {13'b0, got}, 32'd0);
        repeat (300)
            run(gen(), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 10), 1'($urandom));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
